// File: rtl/hash_accumulator.sv
// hash_accumulator
//   Assembles a NUM_WORDS x WORD_WIDTH hash from words that arrive one at a time,
//   in any order. Each index may be written once per hash; a repeated or
//   out-of-range index is dropped and flagged with a one-cycle err_pulse.
//   When every word has been written the result is presented with hash_valid
//   until the consumer takes it with hash_ready.
//
//   Optional feature (macro HASH_FEEDFORWARD_EN): each stored word is
//   word_data + the matching word of prev_hash captured at start, mod 2^WORD_WIDTH.
//   Without the macro the base register and adders are not built.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   start        begin a new hash, capture prev_hash (wins over everything but reset)
//   prev_hash    previous hash, word k at [k*WORD_WIDTH +: WORD_WIDTH]
//   word_valid   word_addr / word_data valid
//   word_ready   high while collecting words
//   word_addr    target word index
//   word_data    word payload
//   hash_valid   hash_vector complete
//   hash_ready   consumer takes the result
//   hash_vector  assembled hash, same layout as prev_hash
//   word_mask    bit k set once word k has been written in the current hash
//   err_pulse    one cycle after a rejected word
module hash_accumulator #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_WORDS  = 8,
  localparam int ADDR_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_WORDS*WORD_WIDTH-1:0] prev_hash,
  input  logic                            word_valid,
  output logic                            word_ready,
  input  logic [ADDR_W-1:0]               word_addr,
  input  logic [WORD_WIDTH-1:0]           word_data,
  output logic                            hash_valid,
  input  logic                            hash_ready,
  output logic [NUM_WORDS*WORD_WIDTH-1:0] hash_vector,
  output logic [NUM_WORDS-1:0]            word_mask,
  output logic                            err_pulse
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDone    = 2'd2
  } state_e;

  state_e                          state_q, state_d;
  logic [NUM_WORDS-1:0]            mask_q, mask_d;
  logic [NUM_WORDS*WORD_WIDTH-1:0] hash_q, hash_d;
  logic                            err_q, err_d;

  // One bit per word index; all zero when word_addr is beyond NUM_WORDS-1.
  logic [NUM_WORDS-1:0]            addr_onehot;
  logic [NUM_WORDS*WORD_WIDTH-1:0] store_vec;
  logic                            in_range;
  logic                            dup;

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_addr
    assign addr_onehot[k] = (word_addr == ADDR_W'(k));
  end

  assign in_range = |addr_onehot;
  assign dup      = |(addr_onehot & mask_q);

`ifdef HASH_FEEDFORWARD_EN
  logic [NUM_WORDS*WORD_WIDTH-1:0] base_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      base_q <= '0;
    end else if (start) begin
      base_q <= prev_hash;
    end
  end

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_ff_add
    assign store_vec[k*WORD_WIDTH +: WORD_WIDTH] =
        word_data + base_q[k*WORD_WIDTH +: WORD_WIDTH];
  end
`else
  logic unused_prev_hash;
  assign unused_prev_hash = ^prev_hash;
  assign store_vec        = {NUM_WORDS{word_data}};
`endif

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    hash_d  = hash_q;
    err_d   = 1'b0;

    if (start) begin
      // A word presented alongside start is dropped silently.
      state_d = StCollect;
      mask_d  = '0;
      hash_d  = '0;
    end else begin
      case (state_q)
        StCollect: begin
          if (word_valid) begin
            if (in_range && !dup) begin
              mask_d = mask_q | addr_onehot;
              for (int k = 0; k < NUM_WORDS; k++) begin
                if (addr_onehot[k]) begin
                  hash_d[k*WORD_WIDTH +: WORD_WIDTH] = store_vec[k*WORD_WIDTH +: WORD_WIDTH];
                end
              end
              if (&mask_d) begin
                state_d = StDone;
              end
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StDone: begin
          if (hash_ready) begin
            state_d = StIdle;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      mask_q  <= '0;
      hash_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      hash_q  <= hash_d;
      err_q   <= err_d;
    end
  end

  assign word_ready  = (state_q == StCollect);
  assign hash_valid  = (state_q == StDone);
  assign hash_vector = hash_q;
  assign word_mask   = mask_q;
  assign err_pulse   = err_q;

endmodule
